// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared TCP transmit types and constants for the send checksum path
// Purpose: header/payload descriptor structs, pipeline stage struct, protocol constants.
// Ports: none (package). Defines `IP_ADDR_W (32) when not already provided.
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

package tcp_pkg;

  localparam int FLOWID_W            = 8;
  localparam int PAYLOAD_LEN_FIELD_W = 16;
  localparam int TCP_HDR_BYTES_DEF   = 20;
  localparam logic [7:0] TCP_PROTO_NUM = 8'd6;

  // Index of the checksum word among the ten 16-bit header words (network order).
  localparam int TCP_CSUM_WORD_IDX = 8;

  // Fields in wire order so the packed vector reads MSB-first as network order.
  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [3:0]  data_offset;
    logic [2:0]  reserved;
    logic [8:0]  flags;
    logic [15:0] win_size;
    logic [15:0] chksum;
    logic [15:0] urg_pointer;
  } tcp_pkt_hdr;

  typedef struct packed {
    logic [31:0]                    payload_addr;
    logic [PAYLOAD_LEN_FIELD_W-1:0] payload_len;
  } payload_buf_struct;

  // One pipeline stage: passthrough fields plus the per-stage arithmetic carry-along.
  typedef struct packed {
    logic [FLOWID_W-1:0]   flowid;
    logic [`IP_ADDR_W-1:0] src_ip;
    logic [`IP_ADDR_W-1:0] dst_ip;
    tcp_pkt_hdr            hdr;
    payload_buf_struct     payload;
    logic [15:0]           tcp_len;
    logic [19:0]           sum;
  } send_csum_stage_struct;

endpackage

// File: rtl/csum_fold16.sv
// rtl/csum_fold16.sv - combinational 20-bit to 16-bit one's-complement end-around-carry fold
// Purpose: fold a 20-bit word sum into a 16-bit one's-complement sum (not complemented).
// Ports: sum_in [19:0] raw sum in; fold_out [15:0] folded sum out.
module csum_fold16 (
  input  logic [19:0] sum_in,
  output logic [15:0] fold_out
);

  logic [16:0] f1;

  // Two passes suffice: after the first, the carry is at most 1 and the low
  // half is then small enough that the second add cannot carry again.
  always_comb begin
    f1       = {1'b0, sum_in[15:0]} + {13'b0, sum_in[19:16]};
    fold_out = f1[15:0] + {15'b0, f1[16]};
  end

endmodule

// File: rtl/send_hdr_csum_pipe.sv
// rtl/send_hdr_csum_pipe.sv - three-stage TCP pseudo-header + header partial checksum pipeline
// Purpose: forward merged transmit packets unchanged with a folded, uncomplemented
//   partial checksum over the pseudo-header and 20-byte TCP header (checksum field as 0).
// Ports: clk, rst (sync active-high); src_csum_tx_* input stream (val/flowid/ips/hdr/payload),
//   csum_src_tx_rdy; csum_dst_tx_* output stream plus csum_dst_tx_hdr_csum, dst_csum_tx_rdy.
// Option: SEND_HDR_CSUM_STATS_EN adds csum_stat_pkt_cnt and csum_stat_stall_cnt.
module send_hdr_csum_pipe
  import tcp_pkg::*;
#(
  parameter int PAYLOAD_LEN_W = 16,
  parameter int TCP_HDR_BYTES = TCP_HDR_BYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_csum_tx_val,
  input  logic [FLOWID_W-1:0]   src_csum_tx_flowid,
  input  logic [`IP_ADDR_W-1:0] src_csum_tx_src_ip,
  input  logic [`IP_ADDR_W-1:0] src_csum_tx_dst_ip,
  input  tcp_pkt_hdr            src_csum_tx_tcp_hdr,
  input  payload_buf_struct     src_csum_tx_payload,
  output logic                  csum_src_tx_rdy,
  output logic                  csum_dst_tx_val,
  output logic [FLOWID_W-1:0]   csum_dst_tx_flowid,
  output logic [`IP_ADDR_W-1:0] csum_dst_tx_src_ip,
  output logic [`IP_ADDR_W-1:0] csum_dst_tx_dst_ip,
  output tcp_pkt_hdr            csum_dst_tx_tcp_hdr,
  output payload_buf_struct     csum_dst_tx_payload,
  output logic [15:0]           csum_dst_tx_hdr_csum,
  input  logic                  dst_csum_tx_rdy
`ifdef SEND_HDR_CSUM_STATS_EN
  ,
  output logic [31:0]           csum_stat_pkt_cnt,
  output logic [31:0]           csum_stat_stall_cnt
`endif
);

  send_csum_stage_struct s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic adv0, adv1, adv2;
  logic [19:0]  word_sum;
  logic [15:0]  fold16;
  logic [159:0] hdr_bits;

  csum_fold16 u_fold (
    .sum_in   (s1_q.sum),
    .fold_out (fold16)
  );

  // Word sum over the S0 contents: pseudo-header words, then the header words
  // with the checksum word skipped (equivalent to treating it as zero).
  always_comb begin
    hdr_bits = s0_q.hdr;
    word_sum = {4'b0, s0_q.src_ip[31:16]} + {4'b0, s0_q.src_ip[15:0]}
             + {4'b0, s0_q.dst_ip[31:16]} + {4'b0, s0_q.dst_ip[15:0]}
             + {12'b0, TCP_PROTO_NUM} + {4'b0, s0_q.tcp_len};
    for (int i = 0; i < 10; i++) begin
      if (i != TCP_CSUM_WORD_IDX) begin
        word_sum = word_sum + {4'b0, hdr_bits[159-16*i -: 16]};
      end
    end
  end

  // Bubble-collapsing advance chain; ready upstream depends only on state and dst ready.
  always_comb begin
    adv2 = ~v2_q | dst_csum_tx_rdy;
    adv1 = ~v1_q | adv2;
    adv0 = ~v0_q | adv1;

    v0_d = v0_q;
    v1_d = v1_q;
    v2_d = v2_q;
    s0_d = s0_q;
    s1_d = s1_q;
    s2_d = s2_q;

    if (adv0) begin
      v0_d = src_csum_tx_val;
      if (src_csum_tx_val) begin
        s0_d.flowid  = src_csum_tx_flowid;
        s0_d.src_ip  = src_csum_tx_src_ip;
        s0_d.dst_ip  = src_csum_tx_dst_ip;
        s0_d.hdr     = src_csum_tx_tcp_hdr;
        s0_d.payload = src_csum_tx_payload;
        // 16-bit length field of the pseudo-header; wraps silently.
        s0_d.tcp_len = 16'(TCP_HDR_BYTES)
                     + 16'(src_csum_tx_payload.payload_len[PAYLOAD_LEN_W-1:0]);
        s0_d.sum     = '0;
      end
    end

    if (adv1) begin
      v1_d = v0_q;
      if (v0_q) begin
        s1_d     = s0_q;
        s1_d.sum = word_sum;
      end
    end

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_d     = s1_q;
        s2_d.sum = {4'b0, fold16};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign csum_src_tx_rdy      = adv0;
  assign csum_dst_tx_val      = v2_q;
  assign csum_dst_tx_flowid   = s2_q.flowid;
  assign csum_dst_tx_src_ip   = s2_q.src_ip;
  assign csum_dst_tx_dst_ip   = s2_q.dst_ip;
  assign csum_dst_tx_tcp_hdr  = s2_q.hdr;
  assign csum_dst_tx_payload  = s2_q.payload;
  assign csum_dst_tx_hdr_csum = s2_q.sum[15:0];

`ifdef SEND_HDR_CSUM_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (v2_q && dst_csum_tx_rdy) pkt_cnt_d = pkt_cnt_q + 32'd1;
    if (v2_q && !dst_csum_tx_rdy) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign csum_stat_pkt_cnt   = pkt_cnt_q;
  assign csum_stat_stall_cnt = stall_cnt_q;
`endif

endmodule
